// File: rtl/wash_phase_timer_if.sv
// -----------------------------------------------------------------------------
// wash_phase_timer_if
// Bundles the controller <-> phase-timer signals.
//   state_in : 3-bit Gray-coded controller state (controller -> timer)
//   pause_n  : lid-open switch, active low (only with WASH_TIMER_PAUSE_EN)
//   wash/water/dewater/alarm : time-up flags (timer -> controller)
//   remain   : seconds left in the current timed phase (timer -> display)
//   sec_tick : one-cycle pulse per elapsed second (timer -> display)
// Modports: master = controller/display side, slave = timer side.
// -----------------------------------------------------------------------------
interface wash_phase_timer_if #(
    parameter int CNT_W = 8
) ();
    logic [2:0]       state_in;
`ifdef WASH_TIMER_PAUSE_EN
    logic             pause_n;
`endif
    logic             wash;
    logic             water;
    logic             dewater;
    logic             alarm;
    logic [CNT_W-1:0] remain;
    logic             sec_tick;

    modport master (
        output state_in,
`ifdef WASH_TIMER_PAUSE_EN
        output pause_n,
`endif
        input  wash, water, dewater, alarm, remain, sec_tick
    );

    modport slave (
        input  state_in,
`ifdef WASH_TIMER_PAUSE_EN
        input  pause_n,
`endif
        output wash, water, dewater, alarm, remain, sec_tick
    );
endinterface

// File: rtl/wash_phase_timer.sv
// -----------------------------------------------------------------------------
// wash_phase_timer
// Times the wash (011), drain (010), spin-dry (110) and alarm (100) phases of
// the washing-machine controller and raises the matching time-up flag when the
// configured number of seconds has elapsed. Flags are levels held until the
// controller changes state.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : wash_phase_timer_if.slave (state_in in; flags, remain, sec_tick out)
// Optional feature: define WASH_TIMER_PAUSE_EN to add bus.pause_n, which
// freezes the prescaler and remaining seconds while low.
// -----------------------------------------------------------------------------
module wash_phase_timer #(
    parameter int CLK_DIV   = 50000000,
    parameter int T_WASH    = 10,
    parameter int T_WATER   = 5,
    parameter int T_DEWATER = 8,
    parameter int T_ALARM   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    wash_phase_timer_if.slave    bus
);
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [PW-1:0]    PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRESC_ZERO = PW'(0);
    localparam logic [CNT_W-1:0] REM_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_ZERO   = CNT_W'(0);

    // Seconds to load for a state code; non-timed codes load zero.
    function automatic logic [CNT_W-1:0] phase_time(input logic [2:0] code);
        logic [CNT_W-1:0] t;
        case (code)
            3'b011:  t = CNT_W'(T_WASH);
            3'b010:  t = CNT_W'(T_WATER);
            3'b110:  t = CNT_W'(T_DEWATER);
            3'b100:  t = CNT_W'(T_ALARM);
            default: t = REM_ZERO;
        endcase
        return t;
    endfunction

    // One-hot flag for a state code: {alarm, dewater, water, wash}; zero if untimed.
    function automatic logic [3:0] phase_flag(input logic [2:0] code);
        logic [3:0] f;
        case (code)
            3'b011:  f = 4'b0001;
            3'b010:  f = 4'b0010;
            3'b110:  f = 4'b0100;
            3'b100:  f = 4'b1000;
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

    logic [2:0]       prev_q,   prev_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [3:0]       flags_q,  flags_d;
    logic             tick_q,   tick_d;
    logic             paused_s;

`ifdef WASH_TIMER_PAUSE_EN
    assign paused_s = ~bus.pause_n;
`else
    assign paused_s = 1'b0;
`endif

    // Next-state: load on state change, otherwise count the current timed phase.
    always_comb begin
        prev_d   = prev_q;
        presc_d  = presc_q;
        remain_d = remain_q;
        flags_d  = flags_q;
        tick_d   = 1'b0;
        if (bus.state_in != prev_q) begin
            // A load edge wins over any expiry that would coincide with it.
            prev_d   = bus.state_in;
            presc_d  = PRESC_ZERO;
            remain_d = phase_time(bus.state_in);
            flags_d  = 4'b0000;
        end else if (phase_flag(prev_q) != 4'b0000) begin
            if (paused_s) begin
                // Frozen: hold prescaler, remain and any raised flag.
                presc_d = presc_q;
            end else if (remain_q != REM_ZERO) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d  = PRESC_ZERO;
                    tick_d   = 1'b1;
                    remain_d = remain_q - REM_ONE;
                    if (remain_q == REM_ONE) begin
                        flags_d = phase_flag(prev_q);
                    end else begin
                        flags_d = 4'b0000;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end else begin
                // Zero seconds left: raise (or keep) the phase flag; covers T = 0.
                flags_d = phase_flag(prev_q);
            end
        end else begin
            presc_d  = PRESC_ZERO;
            remain_d = REM_ZERO;
            flags_d  = 4'b0000;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= 3'b000;
            presc_q  <= PRESC_ZERO;
            remain_q <= REM_ZERO;
            flags_q  <= 4'b0000;
            tick_q   <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            presc_q  <= presc_d;
            remain_q <= remain_d;
            flags_q  <= flags_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.wash     = flags_q[0];
    assign bus.water    = flags_q[1];
    assign bus.dewater  = flags_q[2];
    assign bus.alarm    = flags_q[3];
    assign bus.remain   = remain_q;
    assign bus.sec_tick = tick_q;
endmodule

// File: tb/tb_wash_phase_timer.sv
module tb_wash_phase_timer;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wash_phase_timer_if #(.CNT_W(CNT_W)) bus ();

    wash_phase_timer #(
        .CLK_DIV  (4),
        .T_WASH   (3),
        .T_WATER  (5),
        .T_DEWATER(8),
        .T_ALARM  (3),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.alarm, bus.dewater, bus.water, bus.wash};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.state_in = 3'b000;
`ifdef WASH_TIMER_PAUSE_EN
        bus.pause_n = 1'b1;
`endif
        // 1. reset and idle
        cyc(3);
        check("rst_flags", flags(), 32'd0);
        check("rst_remain", 32'(bus.remain), 32'd0);
        check("rst_tick", 32'(bus.sec_tick), 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(1);
            check("idle_tick", 32'(bus.sec_tick), 32'd0);
            check("idle_flags", flags(), 32'd0);
        end
        check("idle_remain", 32'(bus.remain), 32'd0);

        // 2. supply then wash: 3 s at 4 cycles/s
        bus.state_in = 3'b001;
        cyc(1);
        check("supply_remain", 32'(bus.remain), 32'd0);
        bus.state_in = 3'b011;
        cyc(1);
        check("wash_load", 32'(bus.remain), 32'd3);
        check("wash_load_flags", flags(), 32'd0);
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            check("wash_tick", 32'(bus.sec_tick), (c % 4 == 0) ? 32'd1 : 32'd0);
            check("wash_remain", 32'(bus.remain), 32'(3 - c / 4));
            check("wash_flag", flags(), (c == 12) ? 32'd1 : 32'd0);
        end

        // 3. wash flag holds, then drain
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            check("wash_hold", flags(), 32'd1);
            check("wash_hold_tick", 32'(bus.sec_tick), 32'd0);
        end
        bus.state_in = 3'b010;
        cyc(1);
        check("water_load_flags", flags(), 32'd0);
        check("water_load", 32'(bus.remain), 32'd5);
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            check("water_flag", flags(), (c == 20) ? 32'd2 : 32'd0);
            check("water_remain", 32'(bus.remain), 32'(5 - c / 4));
        end

        // 4. dewater aborted to idle at remain = 5
        bus.state_in = 3'b110;
        cyc(1);
        check("dewater_load", 32'(bus.remain), 32'd8);
        cyc(12);
        check("dewater_mid", 32'(bus.remain), 32'd5);
        bus.state_in = 3'b000;
        cyc(1);
        check("abort_remain", 32'(bus.remain), 32'd0);
        check("abort_flags", flags(), 32'd0);
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            check("abort_no_flag", flags(), 32'd0);
        end

        // Simultaneous expiry and state change: load wins
        bus.state_in = 3'b011;
        cyc(1);
        cyc(11);
        check("sim_pre", 32'(bus.remain), 32'd1);
        bus.state_in = 3'b010;
        cyc(1);
        check("sim_flags", flags(), 32'd0);
        check("sim_remain", 32'(bus.remain), 32'd5);
        check("sim_tick", 32'(bus.sec_tick), 32'd0);

        // 5. reset mid-count in wash
        bus.state_in = 3'b000;
        cyc(1);
        bus.state_in = 3'b011;
        cyc(1);
        cyc(4);
        check("rst_mid_pre", 32'(bus.remain), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_remain", 32'(bus.remain), 32'd0);
        check("rst_mid_flags", flags(), 32'd0);
        bus.state_in = 3'b000;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("post_rst_idle", 32'(bus.remain), 32'd0);
        bus.state_in = 3'b011;
        cyc(1);
        check("post_rst_load", 32'(bus.remain), 32'd3);
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            check("post_rst_wash", flags(), (c == 12) ? 32'd1 : 32'd0);
        end

`ifdef WASH_TIMER_PAUSE_EN
        // 6. alarm with pause after the first tick
        bus.state_in = 3'b100;
        cyc(1);
        check("alarm_load", 32'(bus.remain), 32'd3);
        cyc(4);
        check("alarm_tick1", 32'(bus.sec_tick), 32'd1);
        check("alarm_rem2", 32'(bus.remain), 32'd2);
        bus.pause_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            check("pause_remain", 32'(bus.remain), 32'd2);
            check("pause_tick", 32'(bus.sec_tick), 32'd0);
        end
        bus.pause_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            check("alarm_flag", flags(), (c == 8) ? 32'd8 : 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
